// File: rtl/trig_lut_arbiter.sv
// trig_lut_arbiter: round-robin arbiter sharing one sine ROM among NUM_REQ requesters, 2-stage pipeline
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   req_valid   per-requester request valid
//   req_is_cos  per-requester function select (1 = cos, 0 = sin)
//   req_theta   packed unsigned 3.7 angles, requester i at [i*ANGLE_W +: ANGLE_W]
//   req_ready   one-hot grant, combinational from req_valid and the round-robin pointer
//   resp_valid  one-hot pulse naming the owner of resp_data
//   resp_data   registered ROM result, holds between responses
//   rom_theta   registered ROM address
//   rom_data    combinational ROM output for rom_theta
module trig_lut_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ANGLE_W    = 10,
  parameter int DATA_W     = 16,
  parameter int QTR_OFFSET = 201,
  parameter int PERIOD     = 804
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_is_cos,
  input  logic [NUM_REQ*ANGLE_W-1:0] req_theta,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic [ANGLE_W-1:0]         rom_theta,
  input  logic [DATA_W-1:0]          rom_data
);
  localparam int PTR_W = $clog2(NUM_REQ);
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d, gnt_idx;
  logic               gnt, is_cos, s1_valid_q, s1_valid_d;
  logic [ANGLE_W-1:0] theta_sel, rom_theta_q, rom_theta_d;
  logic [ANGLE_W:0]   cos_sum;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  // first valid requester at or after rr_ptr+1, wrapping
  always_comb begin
    req_ready = '0;
    gnt = 1'b0;
    gnt_idx = rr_ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!gnt && req_valid[PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        gnt = 1'b1;
        gnt_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    if (gnt) req_ready[gnt_idx] = 1'b1;
  end
  // cos(x) = sin(x + pi/2), folded back into one period; one extra bit keeps the sum exact
  always_comb begin
    theta_sel = req_theta[gnt_idx*ANGLE_W +: ANGLE_W];
    is_cos = req_is_cos[gnt_idx];
    cos_sum = {1'b0, theta_sel} + (ANGLE_W+1)'(QTR_OFFSET);
    rom_theta_d = !gnt ? rom_theta_q :
                  !is_cos ? theta_sel :
                  cos_sum >= (ANGLE_W+1)'(PERIOD) ? ANGLE_W'(cos_sum - (ANGLE_W+1)'(PERIOD)) :
                  cos_sum[ANGLE_W-1:0];
    rr_ptr_d = gnt ? gnt_idx : rr_ptr_q;
    owner_d = gnt ? gnt_idx : owner_q;
    s1_valid_d = gnt;
    resp_data_d = s1_valid_q ? rom_data : resp_data_q;
    resp_valid_d = s1_valid_q ? NUM_REQ'(1) << owner_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= PTR_W'(NUM_REQ - 1);
      owner_q <= '0;
      s1_valid_q <= 1'b0;
      rom_theta_q <= '0;
      resp_data_q <= '0;
      resp_valid_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      s1_valid_q <= s1_valid_d;
      rom_theta_q <= rom_theta_d;
      resp_data_q <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end
  assign rom_theta = rom_theta_q;
  assign resp_data = resp_data_q;
  assign resp_valid = resp_valid_q;
endmodule

// File: tb/tb_trig_lut_arbiter.sv
// tb_trig_lut_arbiter: directed self-checking bench with a behavioural sine ROM
module tb_trig_lut_arbiter;
  logic        clk, rst_n;
  logic [3:0]  req_valid, req_is_cos, req_ready, resp_valid;
  logic [39:0] req_theta;
  logic [15:0] resp_data, rom_data;
  logic [9:0]  rom_theta;
  int checks = 0, errors = 0;
  trig_lut_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_is_cos(req_is_cos),
    .req_theta(req_theta), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_data(resp_data), .rom_theta(rom_theta), .rom_data(rom_data)
  );
  function automatic logic [15:0] rom_fn(input logic [9:0] a);
    real x;
    x = $sin(real'(a) / 128.0) * 16384.0;
    return 16'($rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
  endfunction
  assign rom_data = rom_fn(rom_theta);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = '0;
    req_is_cos = '0;
    req_theta = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_data", 32'(resp_data), 32'h0);
    chk("rst_rom_theta", 32'(rom_theta), 32'h0);
    chk("rst_no_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    // 1: single sin request from requester 0
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    chk("t1_rom_theta", 32'(rom_theta), 32'd0);
    chk("t1_no_early_resp", 32'(resp_valid), 32'h0);
    step();
    chk("t1_resp_valid", 32'(resp_valid), 32'h1);
    chk("t1_resp_data", 32'(resp_data), 32'h0000);
    // 2: cos address offset and wrap, back to back on requester 2
    req_valid = 4'b0100;
    req_is_cos = 4'b0100;
    req_theta[20 +: 10] = 10'd100;
    #1;
    chk("t2_ready", 32'(req_ready), 32'h4);
    step();
    chk("t2_cos100", 32'(rom_theta), 32'd301);
    req_theta[20 +: 10] = 10'd700;
    #1;
    chk("t2_ready_b", 32'(req_ready), 32'h4);
    step();
    chk("t2_cos700", 32'(rom_theta), 32'd97);
    chk("t2_resp_a_v", 32'(resp_valid), 32'h4);
    chk("t2_resp_a_d", 32'(resp_data), 32'(rom_fn(10'd301)));
    req_theta[20 +: 10] = 10'd603;
    step();
    req_valid = '0;
    chk("t2_cos603", 32'(rom_theta), 32'd0);
    chk("t2_resp_b_d", 32'(resp_data), 32'(rom_fn(10'd97)));
    step();
    chk("t2_resp_c_v", 32'(resp_valid), 32'h4);
    chk("t2_resp_c_d", 32'(resp_data), 32'(rom_fn(10'd0)));
    step();
    chk("t2_idle", 32'(resp_valid), 32'h0);
    // 3: all requesters valid from reset, sin theta = 10*i
    do_reset();
    req_is_cos = '0;
    for (int i = 0; i < 4; i++) req_theta[i*10 +: 10] = 10'(10 * i);
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("t3_ready%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      step();
      if (c >= 1) begin
        chk($sformatf("t3_rv%0d", c), 32'(resp_valid), 32'(1 << ((c - 1) % 4)));
        chk($sformatf("t3_rd%0d", c), 32'(resp_data), 32'(rom_fn(10'(10 * ((c - 1) % 4)))));
      end
    end
    req_valid = '0;
    step();
    chk("t3_rv_last", 32'(resp_valid), 32'h8);
    chk("t3_rd_last", 32'(resp_data), 32'(rom_fn(10'd30)));
    step();
    chk("t3_drain", 32'(resp_valid), 32'h0);
    // 4: requesters 1 and 3 alternate, 3 was granted last
    req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t4_ready%0d", c), 32'(req_ready), c % 2 == 0 ? 32'h2 : 32'h8);
      step();
      if (c >= 1) chk($sformatf("t4_rv%0d", c), 32'(resp_valid), c % 2 == 1 ? 32'h2 : 32'h8);
    end
    req_valid = '0;
    step();
    step();
    // 5: reset while a result is in flight
    do_reset();
    req_valid = 4'b0001;
    req_theta[0 +: 10] = 10'd50;
    #1;
    chk("t5_ready", 32'(req_ready), 32'h1);
    step();
    chk("t5_rom_theta", 32'(rom_theta), 32'd50);
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_rv", 32'(resp_valid), 32'h0);
    chk("t5_rst_theta", 32'(rom_theta), 32'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t5_no_pulse_a", 32'(resp_valid), 32'h0);
    step();
    chk("t5_no_pulse_b", 32'(resp_valid), 32'h0);
    req_valid = 4'b1111;
    #1;
    chk("t5_prio0", 32'(req_ready), 32'h1);
    req_valid = '0;
    // 6: idle slots between grants, resp_data holds
    req_valid = 4'b0010;
    req_theta[10 +: 10] = 10'd200;
    #1;
    chk("t6_ready_a", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    chk("t6_rv_a", 32'(resp_valid), 32'h2);
    chk("t6_rd_a", 32'(resp_data), 32'(rom_fn(10'd200)));
    step();
    chk("t6_idle_rv", 32'(resp_valid), 32'h0);
    chk("t6_hold_a", 32'(resp_data), 32'(rom_fn(10'd200)));
    step();
    chk("t6_hold_b", 32'(resp_data), 32'(rom_fn(10'd200)));
    req_valid = 4'b0100;
    req_is_cos = '0;
    req_theta[20 +: 10] = 10'd300;
    #1;
    chk("t6_ready_b", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    chk("t6_rv_b", 32'(resp_valid), 32'h4);
    chk("t6_rd_b", 32'(resp_data), 32'(rom_fn(10'd300)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
